verify_stream: RTL and testbench



---
 rtl/verify_pkg.sv | 28 ++
 rtl/verify_lane.sv | 19 +
 rtl/verify_stream.sv | 145 ++++++++++++++
 tb/tb_verify_stream.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/verify_pkg.sv
// Shared types and the byte cipher/hash used by the stream verifier lanes.
package verify_pkg;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] CIPHER_KEY = 8'hC3;
  localparam logic [BYTE_W-1:0] HASH_K     = 8'h3D;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef struct packed {
    logic valid;
    logic hash;
    logic enc;
  } lane_status_t;

  // Cipher is rotate-left-3 then key xor; decrypt undoes it in reverse order.
  function automatic byte_t encrypt(input byte_t p);
    return {p[4:0], p[7:5]} ^ CIPHER_KEY;
  endfunction

  function automatic byte_t decrypt(input byte_t c);
    byte_t t;
    t = c ^ CIPHER_KEY;
    return {t[2:0], t[7:3]};
  endfunction

  function automatic byte_t hash(input byte_t c);
    return (c ^ {c[6:0], c[7]}) + HASH_K;
  endfunction
endpackage

// File: rtl/verify_lane.sv
// One byte lane: decrypt, re-encrypt and hash the ciphertext, compare each result.
module verify_lane
  import verify_pkg::*;
(
  input  byte_t        plain_i,
  input  byte_t        enc_i,
  input  byte_t        ref_hash_i,
  output lane_status_t status_o
);
  byte_t dec, reenc, hsh;

  assign dec   = decrypt(enc_i);
  assign reenc = encrypt(dec);
  assign hsh   = hash(enc_i);

  assign status_o.valid = (dec == plain_i);
  assign status_o.hash  = (hsh == ref_hash_i);
  assign status_o.enc   = (reenc == enc_i);
endmodule

// File: rtl/verify_stream.sv
// Two-stage multi-lane stream verifier with frame status and saturating counters.
// Optional sticky failure status is built only when VERIFY_STICKY_EN is defined.
module verify_stream
  import verify_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BYTE_W*LANES-1:0] in_plain,
  input  logic [BYTE_W*LANES-1:0] in_enc,
  input  logic [BYTE_W*LANES-1:0] in_ref_hash,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_valid_flag,
  output logic [LANES-1:0]        out_hash_match,
  output logic [LANES-1:0]        out_enc_match,
  output logic                    out_last,
  output logic                    out_frame_ok,
  input  logic                    clr_cnt,
  output logic [CNT_W-1:0]        beat_cnt,
  output logic [CNT_W-1:0]        err_cnt,
  output logic [2:0]              err_sticky
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic                    s1_valid_q, s2_valid_q, s1_last_q, s2_last_q;
  logic [BYTE_W*LANES-1:0] s1_plain_q, s1_enc_q, s1_hash_q;
  logic [LANES-1:0]        s2_vf_q, s2_hm_q, s2_em_q;
  logic [LANES-1:0]        vf_c, hm_c, em_c;
  lane_status_t            lane_st [LANES];
  logic                    frame_acc_q, frame_acc_d;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d, err_cnt_q, err_cnt_d;
  logic                    s1_adv, s2_adv, in_hs, out_hs, beat_ok;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv && rst_n;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = s2_valid_q && out_ready;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    verify_lane u_lane (
      .plain_i    (s1_plain_q[g*BYTE_W +: BYTE_W]),
      .enc_i      (s1_enc_q[g*BYTE_W +: BYTE_W]),
      .ref_hash_i (s1_hash_q[g*BYTE_W +: BYTE_W]),
      .status_o   (lane_st[g])
    );
    assign vf_c[g] = lane_st[g].valid;
    assign hm_c[g] = lane_st[g].hash;
    assign em_c[g] = lane_st[g].enc;
  end

  // Stage data loads only on an actual transfer, so idle-bus values never reach state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_last_q  <= 1'b0;
      s1_plain_q <= '0;
      s1_enc_q   <= '0;
      s1_hash_q  <= '0;
      s2_vf_q    <= '0;
      s2_hm_q    <= '0;
      s2_em_q    <= '0;
    end else begin
      if (s1_adv) s1_valid_q <= in_valid;
      if (in_hs) begin
        s1_plain_q <= in_plain;
        s1_enc_q   <= in_enc;
        s1_hash_q  <= in_ref_hash;
        s1_last_q  <= in_last;
      end
      if (s2_adv) s2_valid_q <= s1_valid_q;
      if (s2_adv && s1_valid_q) begin
        s2_vf_q   <= vf_c;
        s2_hm_q   <= hm_c;
        s2_em_q   <= em_c;
        s2_last_q <= s1_last_q;
      end
    end
  end

  assign out_valid      = s2_valid_q;
  assign out_valid_flag = s2_vf_q;
  assign out_hash_match = s2_hm_q;
  assign out_enc_match  = s2_em_q;
  assign out_last       = s2_last_q;
  assign beat_ok        = (&s2_vf_q) & (&s2_hm_q) & (&s2_em_q);
  assign out_frame_ok   = frame_acc_q & beat_ok;

  always_comb begin
    frame_acc_d = frame_acc_q;
    beat_cnt_d  = beat_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (out_hs) frame_acc_d = s2_last_q ? 1'b1 : (frame_acc_q & beat_ok);
    if (clr_cnt) begin
      beat_cnt_d = '0;
      err_cnt_d  = '0;
    end else if (out_hs) begin
      if (beat_cnt_q != CNT_MAX) beat_cnt_d = beat_cnt_q + CNT_ONE;
      if (!beat_ok && err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_acc_q <= 1'b1;
      beat_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_acc_q <= frame_acc_d;
      beat_cnt_q  <= beat_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign beat_cnt = beat_cnt_q;
  assign err_cnt  = err_cnt_q;

`ifdef VERIFY_STICKY_EN
  logic [2:0] sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (clr_cnt) sticky_d = '0;
    else if (out_hs) sticky_d = sticky_q | {~&s2_vf_q, ~&s2_hm_q, ~&s2_em_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sticky_q <= '0;
    else        sticky_q <= sticky_d;
  end

  assign err_sticky = sticky_q;
`else
  assign err_sticky = 3'b000;
`endif
endmodule

// File: tb/tb_verify_stream.sv
// Directed bench for verify_stream: main instance (CNT_W=16) plus a CNT_W=3 twin for saturation.
module tb_verify_stream;
  typedef struct packed {
    logic [31:0] plain;
    logic [31:0] enc;
    logic [31:0] hash;
    logic        last;
  } beat_t;

`ifdef VERIFY_STICKY_EN
  localparam logic [2:0] ST_HASH = 3'b010;
`else
  localparam logic [2:0] ST_HASH = 3'b000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1, clr_cnt = 1'b0;
  logic [31:0] in_plain = '0, in_enc = '0, in_ref_hash = '0;
  logic        in_ready, out_valid, out_last, out_frame_ok;
  logic [3:0]  out_valid_flag, out_hash_match, out_enc_match;
  logic [15:0] beat_cnt, err_cnt;
  logic [2:0]  err_sticky;
  logic        s_in_ready, s_out_valid, s_out_last, s_out_frame_ok;
  logic [3:0]  s_vf, s_hm, s_em;
  logic [2:0]  s_beat_cnt, s_err_cnt, s_sticky;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  verify_stream #(.LANES(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_plain(in_plain), .in_enc(in_enc), .in_ref_hash(in_ref_hash), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_valid_flag(out_valid_flag),
    .out_hash_match(out_hash_match), .out_enc_match(out_enc_match), .out_last(out_last),
    .out_frame_ok(out_frame_ok), .clr_cnt(clr_cnt), .beat_cnt(beat_cnt), .err_cnt(err_cnt),
    .err_sticky(err_sticky)
  );

  verify_stream #(.LANES(4), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_plain(in_plain), .in_enc(in_enc), .in_ref_hash(in_ref_hash), .in_last(in_last),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_valid_flag(s_vf),
    .out_hash_match(s_hm), .out_enc_match(s_em), .out_last(s_out_last),
    .out_frame_ok(s_out_frame_ok), .clr_cnt(clr_cnt), .beat_cnt(s_beat_cnt), .err_cnt(s_err_cnt),
    .err_sticky(s_sticky)
  );

  // Reference cipher written arithmetically: rotl3 then xor key; hash = (c ^ rotl1(c)) + 0x3D.
  function automatic logic [7:0] tb_enc(input logic [7:0] p);
    int v;
    v = ((int'(p) * 8) % 256) + (int'(p) / 32);
    return 8'(v) ^ 8'hC3;
  endfunction

  function automatic logic [7:0] tb_hash(input logic [7:0] c);
    int r;
    r = ((int'(c) * 2) % 256) + (int'(c) / 128);
    return 8'(((int'(c) ^ r) + 'h3D) % 256);
  endfunction

  function automatic beat_t mk_beat(input logic [31:0] plain, input logic last);
    beat_t b;
    b.plain = plain;
    b.last  = last;
    for (int i = 0; i < 4; i++) begin
      b.enc[8*i +: 8]  = tb_enc(plain[8*i +: 8]);
      b.hash[8*i +: 8] = tb_hash(b.enc[8*i +: 8]);
    end
    return b;
  endfunction

  task automatic drive(input beat_t b);
    in_valid = 1'b1; in_plain = b.plain; in_enc = b.enc; in_ref_hash = b.hash; in_last = b.last;
  endtask

  // Entered and left at posedge+1; idle bus carries junk to show it is ignored.
  task automatic send(input beat_t b);
    int t = 0;
    drive(b);
    do begin @(negedge clk); t++; end while (!in_ready && t < 20);
    checks++;
    if (!in_ready) begin failures++; $display("FAIL send_timeout in_ready=%0b required=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_plain = $urandom; in_enc = $urandom; in_ref_hash = $urandom; in_last = 1'b1;
  endtask

  // Leaves the bench at the negedge where out_valid is seen; n counts negedges waited.
  task automatic wait_out(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 20);
    checks++;
    if (!out_valid) begin failures++; $display("FAIL out_timeout out_valid=%0b required=1", out_valid); end
  endtask

  task automatic pulse_clr();
    clr_cnt = 1'b1; @(posedge clk); #1; clr_cnt = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_in_ready got=%0b exp=1", in_ready); end
    checks++;
    if ({out_valid, out_last, out_valid_flag, out_hash_match, out_enc_match} !== 14'h0) begin
      failures++; $display("FAIL rst_outputs got=%h exp=0", {out_valid, out_last, out_valid_flag, out_hash_match, out_enc_match});
    end
    checks++;
    if ({beat_cnt, err_cnt, err_sticky} !== '0) begin
      failures++; $display("FAIL rst_counters beat=%0d err=%0d sticky=%b exp=0", beat_cnt, err_cnt, err_sticky);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    beat_t b;
    int n;
    b.plain = 32'hFFA55A00; b.enc = 32'h3CEE11C3; b.hash = 32'h81707081; b.last = 1'b1;
    send(b);
    wait_out(n);
    checks++; if (n != 2) begin failures++; $display("FAIL basic_latency got=%0d exp=2", n); end
    checks++;
    if ({out_valid_flag, out_hash_match, out_enc_match, out_last, out_frame_ok} !== 14'h3FFF) begin
      failures++; $display("FAIL basic_flags got=%h exp=3fff", {out_valid_flag, out_hash_match, out_enc_match, out_last, out_frame_ok});
    end
    @(posedge clk); #1;
    checks++;
    if (beat_cnt !== 16'd1 || err_cnt !== 16'd0) begin
      failures++; $display("FAIL basic_counts beat=%0d err=%0d exp=1/0", beat_cnt, err_cnt);
    end
  endtask

  task automatic test_frame();
    beat_t b [5];
    int n;
    b[0] = mk_beat(32'h11225A33, 1'b0);
    b[1] = mk_beat(32'h445A5A66, 1'b0);
    b[1].plain[23:16] = 8'h5B;
    b[2] = mk_beat(32'h778899AA, 1'b1);
    b[3] = mk_beat(32'hDEADBEEF, 1'b0);
    b[4] = mk_beat(32'h01234567, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send(b[i]);
      wait_out(n);
      if (i == 1) begin
        checks++;
        if ({out_valid_flag, out_hash_match, out_enc_match} !== 12'hBFF) begin
          failures++; $display("FAIL frame_beat2_flags got=%h exp=bff", {out_valid_flag, out_hash_match, out_enc_match});
        end
      end
      if (i == 2) begin
        checks++;
        if (out_last !== 1'b1 || out_frame_ok !== 1'b0) begin
          failures++; $display("FAIL frame_bad_ok last=%0b ok=%0b exp=1/0", out_last, out_frame_ok);
        end
      end
      if (i == 4) begin
        checks++;
        if (out_last !== 1'b1 || out_frame_ok !== 1'b1) begin
          failures++; $display("FAIL frame_clean_ok last=%0b ok=%0b exp=1/1", out_last, out_frame_ok);
        end
      end
      @(posedge clk); #1;
      if (i == 2) begin
        checks++;
        if (err_cnt !== 16'd1) begin failures++; $display("FAIL frame_err_cnt got=%0d exp=1", err_cnt); end
      end
    end
  endtask

  task automatic test_back_to_back();
    beat_t      bb [8];
    logic [3:0] ev [8], eh [8];
    logic [12:0] prev;
    int idx, k, cyc, ne;
    logic stall, hs_in, hs_out;
    ne = 0;
    for (int j = 0; j < 8; j++) begin
      bb[j] = mk_beat({8'(16*j+3), 8'(16*j+2), 8'(16*j+1), 8'(16*j)}, j == 7);
      ev[j] = 4'hF; eh[j] = 4'hF;
      if (j % 2 == 1) begin bb[j].plain[8*(j%4) +: 8] ^= 8'h80; ev[j][j%4] = 1'b0; end
      if (j % 3 == 0) begin bb[j].hash[8*((j+1)%4) +: 8] ^= 8'h01; eh[j][(j+1)%4] = 1'b0; end
      if (ev[j] != 4'hF || eh[j] != 4'hF) ne++;
    end
    pulse_clr();
    idx = 0; k = 0; cyc = 0; stall = 1'b0; prev = '0;
    drive(bb[0]); out_ready = 1'b1;
    while (k < 8 && cyc < 80) begin
      @(negedge clk);
      if (stall) begin
        checks++;
        if ({out_valid, out_valid_flag, out_hash_match, out_enc_match} !== prev) begin
          failures++; $display("FAIL b2b_stall_stable got=%h exp=%h", {out_valid, out_valid_flag, out_hash_match, out_enc_match}, prev);
        end
      end
      if (!in_ready) begin
        checks++;
        if (!(out_valid && !out_ready)) begin
          failures++; $display("FAIL b2b_in_ready_drop out_valid=%0b out_ready=%0b exp=1/0", out_valid, out_ready);
        end
      end
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      if (hs_out) begin
        checks++;
        if ({out_valid_flag, out_hash_match, out_enc_match, out_last} !== {ev[k], eh[k], 4'hF, k == 7}) begin
          failures++; $display("FAIL b2b_beat%0d got=%h exp=%h", k, {out_valid_flag, out_hash_match, out_enc_match, out_last}, {ev[k], eh[k], 4'hF, k == 7});
        end
        if (k == 7) begin
          checks++;
          if (out_frame_ok !== 1'b0) begin failures++; $display("FAIL b2b_frame_ok got=%0b exp=0", out_frame_ok); end
        end
        k++;
      end
      stall = out_valid && !out_ready;
      prev  = {out_valid, out_valid_flag, out_hash_match, out_enc_match};
      @(posedge clk); #1;
      cyc++;
      if (hs_in) idx++;
      if (idx < 8) drive(bb[idx]);
      else in_valid = 1'b0;
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (k != 8) begin failures++; $display("FAIL b2b_beats_out got=%0d exp=8", k); end
    checks++;
    if (beat_cnt !== 16'd8 || err_cnt !== 16'(ne)) begin
      failures++; $display("FAIL b2b_counts beat=%0d err=%0d exp=8/%0d", beat_cnt, err_cnt, ne);
    end
  endtask

  task automatic test_hash_sticky();
    beat_t b;
    int n;
    pulse_clr();
    b = mk_beat(32'h3C4D5E6F, 1'b1);
    b.hash[7:0] ^= 8'h01;
    send(b);
    wait_out(n);
    checks++;
    if ({out_valid_flag, out_hash_match, out_enc_match} !== 12'hFEF) begin
      failures++; $display("FAIL hash_flags got=%h exp=fef", {out_valid_flag, out_hash_match, out_enc_match});
    end
    @(posedge clk); #1;
    checks++; if (err_sticky !== ST_HASH) begin failures++; $display("FAIL sticky_set got=%b exp=%b", err_sticky, ST_HASH); end
    send(mk_beat(32'h01020304, 1'b1));
    wait_out(n);
    @(posedge clk); #1;
    checks++; if (err_sticky !== ST_HASH) begin failures++; $display("FAIL sticky_hold got=%b exp=%b", err_sticky, ST_HASH); end
    pulse_clr();
    checks++;
    if (err_sticky !== 3'b000 || err_cnt !== 16'd0) begin
      failures++; $display("FAIL sticky_clr sticky=%b err=%0d exp=000/0", err_sticky, err_cnt);
    end
  endtask

  task automatic test_saturation();
    beat_t b;
    int n;
    pulse_clr();
    for (int j = 0; j < 9; j++) begin
      b = mk_beat({8'(j), 8'(j+1), 8'(j+2), 8'(j+3)}, 1'b1);
      b.plain[7:0] ^= 8'h01;
      send(b);
      wait_out(n);
      @(posedge clk); #1;
    end
    checks++;
    if (s_err_cnt !== 3'd7 || s_beat_cnt !== 3'd7) begin
      failures++; $display("FAIL sat_cnt3 err=%0d beat=%0d exp=7/7", s_err_cnt, s_beat_cnt);
    end
    checks++;
    if (err_cnt !== 16'd9 || beat_cnt !== 16'd9) begin
      failures++; $display("FAIL sat_cnt16 err=%0d beat=%0d exp=9/9", err_cnt, beat_cnt);
    end
    send(mk_beat(32'hA0B0C0D0, 1'b1));
    wait_out(n);
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    checks++;
    if ({beat_cnt, err_cnt, s_beat_cnt, s_err_cnt} !== '0) begin
      failures++; $display("FAIL clr_on_hs beat=%0d err=%0d sbeat=%0d serr=%0d exp=0", beat_cnt, err_cnt, s_beat_cnt, s_err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    beat_t b;
    int n;
    b = mk_beat(32'h55667788, 1'b0);
    b.plain[15:8] ^= 8'h01;
    send(b);
    wait_out(n);
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(mk_beat(32'h11111111, 1'b0));
    send(mk_beat(32'h22222222, 1'b1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || beat_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      failures++; $display("FAIL mid_rst valid=%0b beat=%0d err=%0d exp=0/0/0", out_valid, beat_cnt, err_cnt);
    end
    @(posedge clk); #1;
    send(mk_beat(32'h99AABBCC, 1'b1));
    wait_out(n);
    checks++; if (n != 2) begin failures++; $display("FAIL mid_rst_latency got=%0d exp=2", n); end
    checks++; if (out_frame_ok !== 1'b1) begin failures++; $display("FAIL mid_rst_frame_ok got=%0b exp=1", out_frame_ok); end
    @(posedge clk); #1;
    checks++; if (beat_cnt !== 16'd1) begin failures++; $display("FAIL mid_rst_beat_cnt got=%0d exp=1", beat_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frame();
    test_back_to_back();
    test_hash_sticky();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
